// File: rtl/uart_rx_ctrl.sv
// UART receive controller: filters receiver frames into an external FIFO and drains it to a
// valid/ready host channel. Optional macro UART_RX_ERR_CNT_EN adds saturating error counters.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OCC_WIDTH  = 5,
    parameter int THRESH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_en,
    input  logic                  rx_done,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  parity_error,
    input  logic                  frame_error,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  host_valid,
    output logic [DATA_WIDTH-1:0] host_data,
    input  logic                  host_ready,
    input  logic                  err_clr,
    output logic                  par_stky,
    output logic                  frm_stky,
    output logic                  ovr_stky,
    output logic [OCC_WIDTH-1:0]  occ,
    output logic                  irq,
    output logic [7:0]            par_cnt,
    output logic [7:0]            frm_cnt,
    output logic [7:0]            ovr_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [OCC_WIDTH-1:0] OCC_MAX  = {OCC_WIDTH{1'b1}};
    localparam logic [OCC_WIDTH-1:0] OCC_ONE  = {{(OCC_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [OCC_WIDTH-1:0] THRESH_C = OCC_WIDTH'(THRESH);

    logic [1:0]            state_r;
    logic                  fifo_wr_en_r;
    logic [DATA_WIDTH-1:0] fifo_din_r;
    logic                  fifo_rd_en_r;
    logic                  host_valid_r;
    logic [DATA_WIDTH-1:0] host_data_r;
    logic                  par_stky_r;
    logic                  frm_stky_r;
    logic                  ovr_stky_r;
    logic [OCC_WIDTH-1:0]  occ_r;
    logic                  irq_r;

    logic                  par_set_s;
    logic                  frm_set_s;
    logic                  ovr_set_s;
    logic                  accept_s;
    logic                  par_nxt_s;
    logic                  frm_nxt_s;
    logic                  ovr_nxt_s;
    logic [OCC_WIDTH-1:0]  occ_nxt_s;

    // Classify the incoming frame; a disabled receiver never touches any flag.
    always_comb begin
        par_set_s = rx_done & rx_en & parity_error;
        frm_set_s = rx_done & rx_en & frame_error;
        ovr_set_s = rx_done & rx_en & ~parity_error & ~frame_error & fifo_full;
        accept_s  = rx_done & rx_en & ~parity_error & ~frame_error & ~fifo_full;
    end

    // Sticky next state: a new error event beats a simultaneous clear.
    always_comb begin
        par_nxt_s = par_set_s | (par_stky_r & ~err_clr);
        frm_nxt_s = frm_set_s | (frm_stky_r & ~err_clr);
        ovr_nxt_s = ovr_set_s | (ovr_stky_r & ~err_clr);
    end

    // Occupancy next state, saturating at both ends instead of wrapping.
    always_comb begin
        occ_nxt_s = occ_r;
        if (fifo_wr_en_r && !fifo_rd_en_r) begin
            if (occ_r != OCC_MAX) begin
                occ_nxt_s = occ_r + OCC_ONE;
            end else begin
                occ_nxt_s = occ_r;
            end
        end else if (fifo_rd_en_r && !fifo_wr_en_r) begin
            if (occ_r != {OCC_WIDTH{1'b0}}) begin
                occ_nxt_s = occ_r - OCC_ONE;
            end else begin
                occ_nxt_s = occ_r;
            end
        end else begin
            occ_nxt_s = occ_r;
        end
    end

    // Write side: one-cycle FIFO write pulse carrying the registered frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_en_r <= 1'b0;
            fifo_din_r   <= {DATA_WIDTH{1'b0}};
        end else begin
            fifo_wr_en_r <= accept_s;
            if (accept_s) begin
                fifo_din_r <= rx_data;
            end else begin
                fifo_din_r <= fifo_din_r;
            end
        end
    end

    // Status registers; IRQ is computed from the next-state values so it tracks them exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_stky_r <= 1'b0;
            frm_stky_r <= 1'b0;
            ovr_stky_r <= 1'b0;
            occ_r      <= {OCC_WIDTH{1'b0}};
            irq_r      <= 1'b0;
        end else begin
            par_stky_r <= par_nxt_s;
            frm_stky_r <= frm_nxt_s;
            ovr_stky_r <= ovr_nxt_s;
            occ_r      <= occ_nxt_s;
            irq_r      <= (occ_nxt_s >= THRESH_C) | par_nxt_s | frm_nxt_s | ovr_nxt_s;
        end
    end

    // Read FSM: FIFO data arrives the cycle after the read strobe, so LOAD sits between.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            fifo_rd_en_r <= 1'b0;
            host_valid_r <= 1'b0;
            host_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_r      <= ST_FETCH;
                        fifo_rd_en_r <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                        fifo_rd_en_r <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state_r      <= ST_LOAD;
                    fifo_rd_en_r <= 1'b0;
                end
                ST_LOAD: begin
                    state_r      <= ST_HOLD;
                    host_data_r  <= fifo_dout;
                    host_valid_r <= 1'b1;
                end
                ST_HOLD: begin
                    if (host_ready) begin
                        state_r      <= ST_IDLE;
                        host_valid_r <= 1'b0;
                    end else begin
                        state_r      <= ST_HOLD;
                        host_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    fifo_rd_en_r <= 1'b0;
                    host_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] par_cnt_r;
    logic [7:0] frm_cnt_r;
    logic [7:0] ovr_cnt_r;

    function automatic logic [7:0] cnt_next(input logic [7:0] cnt, input logic set, input logic clr);
        if (clr) begin
            return set ? 8'd1 : 8'd0;
        end else if (set && (cnt != 8'hFF)) begin
            return cnt + 8'd1;
        end else begin
            return cnt;
        end
    endfunction

    // Saturating drop-event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_cnt_r <= 8'd0;
            frm_cnt_r <= 8'd0;
            ovr_cnt_r <= 8'd0;
        end else begin
            par_cnt_r <= cnt_next(par_cnt_r, par_set_s, err_clr);
            frm_cnt_r <= cnt_next(frm_cnt_r, frm_set_s, err_clr);
            ovr_cnt_r <= cnt_next(ovr_cnt_r, ovr_set_s, err_clr);
        end
    end

    assign par_cnt = par_cnt_r;
    assign frm_cnt = frm_cnt_r;
    assign ovr_cnt = ovr_cnt_r;
`else
    assign par_cnt = 8'd0;
    assign frm_cnt = 8'd0;
    assign ovr_cnt = 8'd0;
`endif

    assign fifo_wr_en = fifo_wr_en_r;
    assign fifo_din   = fifo_din_r;
    assign fifo_rd_en = fifo_rd_en_r;
    assign host_valid = host_valid_r;
    assign host_data  = host_data_r;
    assign par_stky   = par_stky_r;
    assign frm_stky   = frm_stky_r;
    assign ovr_stky   = ovr_stky_r;
    assign occ        = occ_r;
    assign irq        = irq_r;

endmodule
